// File: rtl/ift_mon_pkg.sv
// Shared constants and types for the information-flow taint monitor.
package ift_mon_pkg;

  // Exposure classification carried on the STATE port
  typedef enum logic [1:0] {
    ST_CLEAN   = 2'd0,
    ST_TAINTED = 2'd1,
    ST_ALERT   = 2'd2
  } state_e;

  localparam int unsigned RUN_W   = 8;
  localparam logic [RUN_W-1:0] RUN_MAX = 8'd255;
  localparam int unsigned CNT_W   = 16;

  // Event record width: {stamp, Q, Q_t}
  function automatic int unsigned ev_width(input int unsigned stamp_w, input int unsigned tw);
    return stamp_w + 1 + tw;
  endfunction

endpackage

// File: rtl/ift_event_fifo.sv
// Synchronous event FIFO; extra pointer bit separates full from empty.
module ift_event_fifo #(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && ready_i;
  // A pop in the same cycle frees the slot the push will land in
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset discards all queued entries
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents are only visible through valid entries
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ift_taint_monitor.sv
// Observes Q/Q_t of an IFT-instrumented cell, classifies sustained taint
// and logs every taint-vector change as a stamped event.
module ift_taint_monitor
  import ift_mon_pkg::*;
#(
  parameter int unsigned TW           = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned STAMP_W      = 16,
  parameter int unsigned ALERT_THRESH = 4
) (
  input  logic                                CLK,
  input  logic                                CLR,
  input  logic                                EN,
  input  logic                                Q,
  input  logic [TW-1:0]                       Q_t,
  input  logic                                ACK,
  input  logic                                EV_READY,
  output logic                                EV_VALID,
  output logic [ev_width(STAMP_W, TW)-1:0]    EV_DATA,
  output logic                                ALERT,
  output logic [1:0]                          STATE,
  output logic [CNT_W-1:0]                    TAINT_CNT,
  output logic                                OVERFLOW
);

  localparam int unsigned EV_W = ev_width(STAMP_W, TW);
  localparam logic [RUN_W-1:0] THRESH = RUN_W'(ALERT_THRESH);

  state_e               state_q;
  logic                 alert_q;
  logic [STAMP_W-1:0]   stamp_q;
  logic [RUN_W-1:0]     run_q;
  logic [RUN_W-1:0]     run_d;
  logic [CNT_W-1:0]     taint_cnt_q;
  logic [TW-1:0]        prev_qt_q;
  logic                 overflow_q;
  logic                 tainted;
  logic                 ev_push;
  logic [EV_W-1:0]      ev_din;
  logic                 ev_drop;

  assign tainted = |Q_t;
  assign ev_push = EN && (Q_t != prev_qt_q);
  assign ev_din  = {stamp_q, Q, Q_t};

  // Run length of consecutive tainted samples, saturating at RUN_MAX
  always_comb begin
    run_d = '0;
    if (tainted) run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
  end

  // Classification FSM; ALERT is sticky until acknowledged on a clean sample
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_CLEAN;
      alert_q <= 1'b0;
    end else if (EN) begin
      case (state_q)
        ST_ALERT: begin
          if (ACK && !tainted) begin
            state_q <= ST_CLEAN;
            alert_q <= 1'b0;
          end
        end
        default: begin
          if (run_d >= THRESH) begin
            state_q <= ST_ALERT;
            alert_q <= 1'b1;
          end else if (tainted) begin
            state_q <= ST_TAINTED;
            alert_q <= 1'b0;
          end else begin
            state_q <= ST_CLEAN;
            alert_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Sample-side counters and change tracking, all frozen when EN is low
  always_ff @(posedge CLK) begin
    if (CLR) begin
      stamp_q     <= '0;
      run_q       <= '0;
      taint_cnt_q <= '0;
      prev_qt_q   <= '0;
    end else if (EN) begin
      stamp_q   <= stamp_q + STAMP_W'(1);
      run_q     <= run_d;
      prev_qt_q <= Q_t;
      if (tainted && (taint_cnt_q != '1)) taint_cnt_q <= taint_cnt_q + CNT_W'(1);
    end
  end

  // Sticky record of any event lost to a full queue
  always_ff @(posedge CLK) begin
    if (CLR)          overflow_q <= 1'b0;
    else if (ev_drop) overflow_q <= 1'b1;
  end

  ift_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (CLR),
    .push_i  (ev_push),
    .data_i  (ev_din),
    .ready_i (EV_READY),
    .valid_o (EV_VALID),
    .data_o  (EV_DATA),
    .drop_o  (ev_drop)
  );

  assign STATE     = state_q;
  assign ALERT     = alert_q;
  assign TAINT_CNT = taint_cnt_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_ift_taint_monitor.sv
// Directed bench for ift_taint_monitor (TW=32, DEPTH=8, STAMP_W=16, THRESH=4).
module tb_ift_taint_monitor;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        EN;
  logic        Q;
  logic [31:0] Q_t;
  logic        ACK;
  logic        EV_READY;
  logic        EV_VALID;
  logic [48:0] EV_DATA;
  logic        ALERT;
  logic [1:0]  STATE;
  logic [15:0] TAINT_CNT;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_stamp;
  logic [15:0] exp_cnt;

  typedef struct packed {
    logic        en;
    logic        q;
    logic [31:0] qt;
    logic        ack;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        vld;
  } vec_t;

  vec_t tbl [17];

  ift_taint_monitor dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .EN        (EN),
    .Q         (Q),
    .Q_t       (Q_t),
    .ACK       (ACK),
    .EV_READY  (EV_READY),
    .EV_VALID  (EV_VALID),
    .EV_DATA   (EV_DATA),
    .ALERT     (ALERT),
    .STATE     (STATE),
    .TAINT_CNT (TAINT_CNT),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] mkev(input logic [15:0] s, input logic q, input logic [31:0] qt);
    return 64'({s, q, qt});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the reference stamp/count track the inputs held across the edge
  task automatic step();
    if (CLR) begin
      exp_stamp = '0;
      exp_cnt   = '0;
    end else if (EN) begin
      exp_stamp = exp_stamp + 16'd1;
      if ((|Q_t) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  initial begin
    logic [15:0] s0;
    logic [15:0] es;

    CLR = 1'b1; EN = 1'b0; Q = 1'b0; Q_t = '0; ACK = 1'b0; EV_READY = 1'b0;
    exp_stamp = '0; exp_cnt = '0;
    step();
    step();
    CLR = 1'b0;

    chk("rst_state",    64'(STATE),     64'd0);
    chk("rst_alert",    64'(ALERT),     64'd0);
    chk("rst_valid",    64'(EV_VALID),  64'd0);
    chk("rst_data",     64'(EV_DATA),   64'd0);
    chk("rst_cnt",      64'(TAINT_CNT), 64'd0);
    chk("rst_overflow", 64'(OVERFLOW),  64'd0);

    //            en    q     qt      ack   st    cnt    vld
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd1, 16'd1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd1, 16'd2, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd1, 16'd3, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd2, 16'd4, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 2'd0, 16'd4, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd1, 16'd5, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd1, 16'd6, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd1, 16'd7, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h1, 1'b0, 2'd2, 16'd8, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h1, 1'b1, 2'd2, 16'd9, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 2'd2, 16'd9, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 2'd0, 16'd9, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'h0, 1'b0, 2'd0, 16'd9, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 16'd9, 1'b0};

    EV_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      EN = tbl[i].en; Q = tbl[i].q; Q_t = tbl[i].qt; ACK = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_state", i), 64'(STATE),     64'(tbl[i].st));
      chk($sformatf("tbl%0d_alert", i), 64'(ALERT),     64'(tbl[i].st == 2'd2));
      chk($sformatf("tbl%0d_cnt", i),   64'(TAINT_CNT), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 64'(EV_VALID),  64'(tbl[i].vld));
    end
    ACK = 1'b0; EN = 1'b1; Q = 1'b0; Q_t = '0;

    // Event ordering and one-cycle push-to-valid latency, consumer always ready
    pulse_clr();
    EV_READY = 1'b1;
    Q_t = 32'h0; step();
    chk("ev_s0_valid", 64'(EV_VALID), 64'd0);
    Q_t = 32'h1; step();
    chk("ev_s1_valid", 64'(EV_VALID), 64'd1);
    chk("ev_s1_data",  64'(EV_DATA),  mkev(16'd1, 1'b0, 32'h1));
    Q_t = 32'h1; step();
    chk("ev_s2_valid", 64'(EV_VALID), 64'd0);
    Q = 1'b1; Q_t = 32'h3; step();
    chk("ev_s3_valid", 64'(EV_VALID), 64'd1);
    chk("ev_s3_data",  64'(EV_DATA),  mkev(16'd3, 1'b1, 32'h3));
    Q = 1'b0; Q_t = 32'h0; step();
    chk("ev_s4_valid", 64'(EV_VALID), 64'd1);
    chk("ev_s4_data",  64'(EV_DATA),  mkev(16'd4, 1'b0, 32'h0));
    step();
    chk("ev_s5_valid", 64'(EV_VALID), 64'd0);

    // Fill to capacity, push-with-pop while full, then a dropped push
    EV_READY = 1'b0;
    s0 = exp_stamp;
    for (int i = 1; i <= 8; i++) begin
      Q_t = 32'(i);
      step();
    end
    chk("full_overflow", 64'(OVERFLOW), 64'd0);
    chk("full_head",     64'(EV_DATA),  mkev(s0, 1'b0, 32'h1));
    EV_READY = 1'b1; Q_t = 32'd9; step();
    chk("pushpop_overflow", 64'(OVERFLOW), 64'd0);
    EV_READY = 1'b0; Q_t = 32'd10; step();
    chk("drop_overflow", 64'(OVERFLOW), 64'd1);
    chk("drop_state",    64'(STATE),    64'd2);

    // Drain with sampling disabled and the input fully tainted
    EN = 1'b0; Q_t = 32'hFFFF_FFFF; EV_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(EV_VALID), 64'd1);
      chk($sformatf("drain%0d_data", k),  64'(EV_DATA),  mkev(s0 + 16'(k + 1), 1'b0, 32'(k + 2)));
      step();
    end
    chk("drain_empty",   64'(EV_VALID),  64'd0);
    chk("en0_state",     64'(STATE),     64'd2);
    chk("en0_cnt",       64'(TAINT_CNT), 64'(exp_cnt));
    chk("en0_overflow",  64'(OVERFLOW),  64'd1);

    // Stamp must resume from where sampling stopped
    EN = 1'b1; Q_t = 32'h0; EV_READY = 1'b0;
    es = exp_stamp;
    step();
    chk("resume_valid", 64'(EV_VALID), 64'd1);
    chk("resume_data",  64'(EV_DATA),  mkev(es, 1'b0, 32'h0));
    chk("resume_state", 64'(STATE),    64'd2);
    Q_t = 32'h5; step();
    Q_t = 32'h6; step();
    chk("pre_clr_state", 64'(STATE), 64'd2);
    chk("pre_clr_cnt",   64'(TAINT_CNT), 64'(exp_cnt));

    // Reset with three queued events and ALERT set
    pulse_clr();
    chk("clr_state",    64'(STATE),     64'd0);
    chk("clr_alert",    64'(ALERT),     64'd0);
    chk("clr_valid",    64'(EV_VALID),  64'd0);
    chk("clr_data",     64'(EV_DATA),   64'd0);
    chk("clr_cnt",      64'(TAINT_CNT), 64'd0);
    chk("clr_overflow", 64'(OVERFLOW),  64'd0);
    Q_t = 32'h7; step();
    chk("post_clr_data",  64'(EV_DATA),   mkev(16'd0, 1'b0, 32'h7));
    chk("post_clr_state", 64'(STATE),     64'd1);
    chk("post_clr_cnt",   64'(TAINT_CNT), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
